zmod_rxclk_ctrl: RTL and testbench

//  Supervisor for the Zmod RX clocking MMCM: sequences MMCM reset, qualifies LOCKED, releases
//  per-domain resets staggered, and drives the MMCM dynamic phase-shift port (PSEN/PSINCDEC/PSDONE)
//  so software/training logic can slide the RX sample clock. Runs on a free-running fabric clock;

---
 rtl/zmod_rxclk_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_zmod_rxclk_ctrl.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zmod_rxclk_ctrl.sv
// Zmod RX clocking MMCM supervisor: reset sequencing, lock qualification,
// staggered domain reset release and dynamic phase-shift stepping.
module zmod_rxclk_ctrl #(
    parameter int unsigned NUM_DOM       = 3,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned STAGGER       = 8,
    parameter int unsigned PS_W          = 10,
    parameter int unsigned PS_TIMEOUT    = 64
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                pll_locked,
    output logic                pll_rst,
    output logic                ps_en,
    output logic                ps_incdec,
    input  logic                ps_done,
    input  logic                ps_req,
    input  logic                ps_dir,
    input  logic [PS_W-1:0]     ps_count,
    output logic                ps_busy,
    output logic                ps_err,
    output logic signed [PS_W:0] phase_pos,
    output logic [NUM_DOM-1:0]  dom_rstn,
    output logic                ready,
    output logic [7:0]          unlock_cnt
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned REL_SPAN = (NUM_DOM - 1) * STAGGER;
    localparam int unsigned CNT_MAX  = max2(max2(max2(RST_CYCLES, LOCK_TIMEOUT),
                                                 max2(SETTLE_CYCLES, PS_TIMEOUT)), REL_SPAN);
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned PHS_W    = PS_W + 1;

    typedef enum logic [2:0] {
        ST_RST       = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_PS_STEP   = 3'd5,
        ST_PS_WAIT   = 3'd6
    } state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     lk_meta_q;
    logic                     lk_q;
    logic                     pll_rst_q;
    logic                     ps_en_q;
    logic                     ps_incdec_q;
    logic                     ps_busy_q;
    logic                     ps_err_q;
    logic signed [PS_W:0]     phase_pos_q;
    logic [NUM_DOM-1:0]       dom_rstn_q;
    logic                     ready_q;
    logic [7:0]               unlock_cnt_q;
    logic                     dir_q;
    logic [PS_W-1:0]          rem_q;
    logic                     lock_lost;
    logic [NUM_DOM-1:0]       rel_hit;

    // Two-flop synchroniser for the asynchronous MMCM LOCKED signal
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lk_meta_q <= 1'b0;
            lk_q      <= 1'b0;
        end else begin
            lk_meta_q <= pll_locked;
            lk_q      <= lk_meta_q;
        end
    end

    // Lock loss only matters once the clock has been qualified
    always_comb begin
        lock_lost = 1'b0;
        if (!lk_q && (state_q == ST_RELEASE || state_q == ST_RUN ||
                      state_q == ST_PS_STEP || state_q == ST_PS_WAIT)) begin
            lock_lost = 1'b1;
        end
    end

    // Per-domain release strobe: domain g is released when the release counter hits g*STAGGER
    for (genvar g = 0; g < int'(NUM_DOM); g++) begin : g_rel
        assign rel_hit[g] = (cnt_q == CNT_W'(g * STAGGER));
    end

    // Supervisor FSM with registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_RST;
            cnt_q        <= '0;
            pll_rst_q    <= 1'b1;
            ps_en_q      <= 1'b0;
            ps_incdec_q  <= 1'b0;
            ps_busy_q    <= 1'b0;
            ps_err_q     <= 1'b0;
            phase_pos_q  <= '0;
            dom_rstn_q   <= '0;
            ready_q      <= 1'b0;
            unlock_cnt_q <= '0;
            dir_q        <= 1'b0;
            rem_q        <= '0;
        end else begin
            ps_en_q <= 1'b0;
            if (lock_lost) begin
                // Drop every domain, discard outstanding steps, re-sequence the MMCM
                state_q    <= ST_RST;
                cnt_q      <= '0;
                pll_rst_q  <= 1'b1;
                ps_busy_q  <= 1'b0;
                dom_rstn_q <= '0;
                ready_q    <= 1'b0;
                rem_q      <= '0;
                if (unlock_cnt_q != 8'hFF) begin
                    unlock_cnt_q <= unlock_cnt_q + 8'd1;
                end
            end else begin
                unique case (state_q)
                    ST_RST: begin
                        pll_rst_q   <= 1'b1;
                        phase_pos_q <= '0;
                        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                            pll_rst_q <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= ST_WAIT_LOCK;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (lk_q) begin
                            cnt_q   <= '0;
                            state_q <= ST_SETTLE;
                        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                            cnt_q     <= '0;
                            pll_rst_q <= 1'b1;
                            state_q   <= ST_RST;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_SETTLE: begin
                        if (!lk_q) begin
                            cnt_q   <= '0;
                            state_q <= ST_WAIT_LOCK;
                        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                            cnt_q   <= '0;
                            state_q <= ST_RELEASE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_RELEASE: begin
                        dom_rstn_q <= dom_rstn_q | rel_hit;
                        if (cnt_q == CNT_W'(REL_SPAN)) begin
                            cnt_q   <= '0;
                            ready_q <= 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        // A zero-length request is accepted and completes with no step
                        if (ps_req && (ps_count != '0)) begin
                            dir_q     <= ps_dir;
                            rem_q     <= ps_count;
                            ps_busy_q <= 1'b1;
                            state_q   <= ST_PS_STEP;
                        end
                    end
                    ST_PS_STEP: begin
                        ps_en_q     <= 1'b1;
                        ps_incdec_q <= dir_q;
                        cnt_q       <= '0;
                        state_q     <= ST_PS_WAIT;
                    end
                    ST_PS_WAIT: begin
                        if (ps_done) begin
                            phase_pos_q <= dir_q ? (phase_pos_q + PHS_W'(1))
                                                 : (phase_pos_q - PHS_W'(1));
                            rem_q       <= rem_q - PS_W'(1);
                            cnt_q       <= '0;
                            if (rem_q == PS_W'(1)) begin
                                ps_busy_q <= 1'b0;
                                state_q   <= ST_RUN;
                            end else begin
                                state_q <= ST_PS_STEP;
                            end
                        end else if (cnt_q == CNT_W'(PS_TIMEOUT - 1)) begin
                            // MMCM stopped answering: flag it and rebuild the clock from scratch
                            ps_err_q   <= 1'b1;
                            ps_busy_q  <= 1'b0;
                            dom_rstn_q <= '0;
                            ready_q    <= 1'b0;
                            rem_q      <= '0;
                            cnt_q      <= '0;
                            pll_rst_q  <= 1'b1;
                            state_q    <= ST_RST;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        state_q   <= ST_RST;
                    end
                endcase
            end
        end
    end

    // A phase step must never be issued while the MMCM is held in reset
    a_no_psen_in_rst : assert property (@(posedge clk) disable iff (!resetn) !(ps_en_q && pll_rst_q));

    assign pll_rst    = pll_rst_q;
    assign ps_en      = ps_en_q;
    assign ps_incdec  = ps_incdec_q;
    assign ps_busy    = ps_busy_q;
    assign ps_err     = ps_err_q;
    assign phase_pos  = phase_pos_q;
    assign dom_rstn   = dom_rstn_q;
    assign ready      = ready_q;
    assign unlock_cnt = unlock_cnt_q;

endmodule

// File: tb/tb_zmod_rxclk_ctrl.sv
// Directed bench for zmod_rxclk_ctrl with a simple MMCM lock / PSDONE model.
module tb_zmod_rxclk_ctrl;

    localparam int unsigned NUM_DOM       = 3;
    localparam int unsigned RST_CYCLES    = 16;
    localparam int unsigned LOCK_TIMEOUT  = 200;
    localparam int unsigned SETTLE_CYCLES = 32;
    localparam int unsigned STAGGER       = 8;
    localparam int unsigned PS_W          = 10;
    localparam int unsigned PS_TIMEOUT    = 64;

    logic               clk = 1'b0;
    logic               resetn;
    logic               pll_locked;
    logic               pll_rst;
    logic               ps_en;
    logic               ps_incdec;
    logic               ps_done;
    logic               ps_req;
    logic               ps_dir;
    logic [PS_W-1:0]    ps_count;
    logic               ps_busy;
    logic               ps_err;
    logic signed [PS_W:0] phase_pos;
    logic [NUM_DOM-1:0] dom_rstn;
    logic               ready;
    logic [7:0]         unlock_cnt;

    int asserts = 0;
    int fails   = 0;

    // model controls
    bit auto_lock = 0;
    bit drop_req  = 0;
    bit withhold  = 0;
    int lock_dly  = 10;
    int lock_ctr  = 0;
    int done_dly  = 12;
    int pend      = 0;
    int pen_cnt   = 0;
    bit pen_prev  = 0;

    zmod_rxclk_ctrl #(
        .NUM_DOM(NUM_DOM), .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .SETTLE_CYCLES(SETTLE_CYCLES), .STAGGER(STAGGER), .PS_W(PS_W), .PS_TIMEOUT(PS_TIMEOUT)
    ) dut (
        .clk(clk), .resetn(resetn), .pll_locked(pll_locked), .pll_rst(pll_rst),
        .ps_en(ps_en), .ps_incdec(ps_incdec), .ps_done(ps_done), .ps_req(ps_req),
        .ps_dir(ps_dir), .ps_count(ps_count), .ps_busy(ps_busy), .ps_err(ps_err),
        .phase_pos(phase_pos), .dom_rstn(dom_rstn), .ready(ready), .unlock_cnt(unlock_cnt)
    );

    always #5 clk = ~clk;

    // MMCM lock model: unlocked while in reset, locks lock_dly cycles after release
    initial begin
        forever begin
            @(negedge clk);
            if (pll_rst) begin
                lock_ctr = 0;
                drop_req = 0;
                if (auto_lock) pll_locked = 1'b0;
            end else if (drop_req) begin
                pll_locked = 1'b0;
            end else if (auto_lock) begin
                if (lock_ctr >= lock_dly) pll_locked = 1'b1;
                else lock_ctr++;
            end
        end
    end

    // PSDONE model: one-cycle pulse done_dly cycles after each PSEN
    initial begin
        ps_done = 1'b0;
        forever begin
            @(negedge clk);
            ps_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) ps_done = 1'b1;
            end
            if (ps_en && !withhold) pend = done_dly;
        end
    end

    // PSEN monitor: counts pulses, flags over-long pulses and pulses during MMCM reset
    initial begin
        forever begin
            @(negedge clk);
            if (ps_en) begin
                pen_cnt++;
                asserts++;
                if (pen_prev || pll_rst) begin
                    fails++;
                    $display("FAIL psen_pulse: ps_en=1 prev=%0b pll_rst=%0b, required single pulse outside reset",
                             pen_prev, pll_rst);
                end
            end
            pen_prev = ps_en;
        end
    end

    task automatic wait_ready(input int limit, output bit ok);
        ok = 0;
        for (int n = 0; n < limit; n++) begin
            if (ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_req(input bit dir, input int cnt);
        ps_req   = 1'b1;
        ps_dir   = dir;
        ps_count = PS_W'(cnt);
        @(negedge clk);
        ps_req   = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 0;
        for (int n = 0; n < limit; n++) begin
            if (!ps_busy) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int n;
        repeat (3) @(negedge clk);
        asserts++;
        if ({pll_rst, ps_en, ps_incdec, ps_busy, ps_err, ready} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, required 100000",
                     {pll_rst, ps_en, ps_incdec, ps_busy, ps_err, ready});
        end
        asserts++;
        if (phase_pos !== '0 || dom_rstn !== '0 || unlock_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_regs: phase=%0d dom=%b unlock=%0d, required 0/000/0",
                     phase_pos, dom_rstn, unlock_cnt);
        end
        resetn = 1'b1;
        n = 0;
        while (pll_rst && n < 100) begin
            @(negedge clk);
            n++;
        end
        asserts++;
        if (n != 16) begin
            fails++;
            $display("FAIL reset_pll_rst_len: got %0d cycles, required 16", n);
        end
    endtask

    task automatic test_no_lock;
        int n;
        n = 0;
        while (!pll_rst && n < 1000) begin
            @(negedge clk);
            n++;
        end
        asserts++;
        if (n != 200) begin
            fails++;
            $display("FAIL nolock_timeout: pll_rst low %0d cycles, required 200", n);
        end
        n = 0;
        while (pll_rst && n < 100) begin
            @(negedge clk);
            n++;
        end
        asserts++;
        if (n != 16) begin
            fails++;
            $display("FAIL nolock_repulse: pll_rst high %0d cycles, required 16", n);
        end
        asserts++;
        if (ready !== 1'b0 || dom_rstn !== 3'b000) begin
            fails++;
            $display("FAIL nolock_ready: ready=%b dom=%b, required 0/000", ready, dom_rstn);
        end
    endtask

    task automatic test_lock_sequence;
        int n;
        repeat (100) @(negedge clk);
        pll_locked = 1'b1;
        n = 0;
        while (dom_rstn == '0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        asserts++;
        if (n != 36) begin
            fails++;
            $display("FAIL lock_settle_latency: got %0d cycles, required 36", n);
        end
        asserts++;
        if (dom_rstn !== 3'b001 || ready !== 1'b0) begin
            fails++;
            $display("FAIL lock_dom0: dom=%b ready=%b, required 001/0", dom_rstn, ready);
        end
        repeat (7) @(negedge clk);
        asserts++;
        if (dom_rstn !== 3'b001) begin
            fails++;
            $display("FAIL lock_dom1_early: dom=%b, required 001", dom_rstn);
        end
        @(negedge clk);
        asserts++;
        if (dom_rstn !== 3'b011 || ready !== 1'b0) begin
            fails++;
            $display("FAIL lock_dom1: dom=%b ready=%b, required 011/0", dom_rstn, ready);
        end
        repeat (8) @(negedge clk);
        asserts++;
        if (dom_rstn !== 3'b111 || ready !== 1'b1) begin
            fails++;
            $display("FAIL lock_dom2: dom=%b ready=%b, required 111/1", dom_rstn, ready);
        end
        lock_ctr  = lock_dly;
        auto_lock = 1;
    endtask

    task automatic test_phase_inc;
        bit ok;
        pen_cnt = 0;
        send_req(1'b1, 5);
        asserts++;
        if (ps_busy !== 1'b1) begin
            fails++;
            $display("FAIL inc_busy: ps_busy=%b, required 1", ps_busy);
        end
        wait_idle(1000, ok);
        asserts++;
        if (!ok || pen_cnt != 5 || phase_pos !== 11'sd5 || ps_incdec !== 1'b1) begin
            fails++;
            $display("FAIL inc_result: done=%0b pulses=%0d phase=%0d incdec=%b, required 1/5/5/1",
                     ok, pen_cnt, phase_pos, ps_incdec);
        end
    endtask

    task automatic test_phase_dec;
        bit ok;
        logic signed [PS_W:0] exp_pos;
        exp_pos = -11'sd2;
        pen_cnt = 0;
        send_req(1'b0, 7);
        repeat (3) @(negedge clk);
        send_req(1'b1, 3);
        wait_idle(1500, ok);
        asserts++;
        if (!ok || pen_cnt != 7 || phase_pos !== exp_pos || ps_incdec !== 1'b0) begin
            fails++;
            $display("FAIL dec_result: done=%0b pulses=%0d phase=%0d incdec=%b, required 1/7/-2/0",
                     ok, pen_cnt, phase_pos, ps_incdec);
        end
        pen_cnt = 0;
        send_req(1'b1, 0);
        asserts++;
        if (ps_busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_busy: ps_busy=%b, required 0", ps_busy);
        end
        repeat (20) @(negedge clk);
        asserts++;
        if (pen_cnt != 0 || phase_pos !== exp_pos) begin
            fails++;
            $display("FAIL zero_count: pulses=%0d phase=%0d, required 0/-2", pen_cnt, phase_pos);
        end
    endtask

    task automatic test_lock_loss;
        bit ok;
        int n;
        pen_cnt = 0;
        send_req(1'b1, 5);
        n = 0;
        while (pen_cnt < 3 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        pll_locked = 1'b0;
        drop_req   = 1;
        repeat (2) @(negedge clk);
        asserts++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL loss_early: ready=%b after 2 cycles, required 1", ready);
        end
        @(negedge clk);
        asserts++;
        if (ready !== 1'b0 || dom_rstn !== 3'b000 || ps_busy !== 1'b0 || unlock_cnt !== 8'd1) begin
            fails++;
            $display("FAIL loss_drop: ready=%b dom=%b busy=%b unlock=%0d, required 0/000/0/1",
                     ready, dom_rstn, ps_busy, unlock_cnt);
        end
        @(negedge clk);
        asserts++;
        if (phase_pos !== '0 || pll_rst !== 1'b1) begin
            fails++;
            $display("FAIL loss_rst: phase=%0d pll_rst=%b, required 0/1", phase_pos, pll_rst);
        end
        wait_ready(1000, ok);
        asserts++;
        if (!ok || dom_rstn !== 3'b111 || phase_pos !== '0 || ps_busy !== 1'b0) begin
            fails++;
            $display("FAIL loss_relock: ready=%0b dom=%b phase=%0d busy=%b, required 1/111/0/0",
                     ok, dom_rstn, phase_pos, ps_busy);
        end
    endtask

    task automatic test_ps_timeout;
        bit ok;
        int n;
        withhold = 1;
        send_req(1'b1, 2);
        n = 0;
        while (!ps_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!ps_err && n < 500) begin
            @(negedge clk);
            n++;
        end
        asserts++;
        if (n != 64) begin
            fails++;
            $display("FAIL timeout_len: ps_err after %0d cycles, required 64", n);
        end
        asserts++;
        if (pll_rst !== 1'b1 || ps_busy !== 1'b0 || ready !== 1'b0 || unlock_cnt !== 8'd1) begin
            fails++;
            $display("FAIL timeout_state: pll_rst=%b busy=%b ready=%b unlock=%0d, required 1/0/0/1",
                     pll_rst, ps_busy, ready, unlock_cnt);
        end
        withhold = 0;
        wait_ready(1000, ok);
        asserts++;
        if (!ok || ps_err !== 1'b1 || phase_pos !== '0) begin
            fails++;
            $display("FAIL timeout_sticky: ready=%0b ps_err=%b phase=%0d, required 1/1/0",
                     ok, ps_err, phase_pos);
        end
    endtask

    task automatic test_unlock_saturation;
        bit ok;
        int n;
        for (int i = 0; i < 256; i++) begin
            if (i == 254) begin
                asserts++;
                if (unlock_cnt !== 8'd255) begin
                    fails++;
                    $display("FAIL unlock_reach: unlock=%0d, required 255", unlock_cnt);
                end
            end
            wait_ready(500, ok);
            if (!ok) begin
                asserts++;
                fails++;
                $display("FAIL unlock_relock: no ready at iteration %0d", i);
                break;
            end
            #1;
            pll_locked = 1'b0;
            drop_req   = 1;
            n = 0;
            while (!pll_rst && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        asserts++;
        if (unlock_cnt !== 8'd255) begin
            fails++;
            $display("FAIL unlock_sat: unlock=%0d, required 255", unlock_cnt);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        asserts++;
        if ({pll_rst, ps_err, ps_busy, ready} !== 4'b1000 || unlock_cnt !== 8'd0 ||
            dom_rstn !== 3'b000 || phase_pos !== '0) begin
            fails++;
            $display("FAIL async_reset: rst/err/busy/ready=%b unlock=%0d dom=%b phase=%0d, required 1000/0/000/0",
                     {pll_rst, ps_err, ps_busy, ready}, unlock_cnt, dom_rstn, phase_pos);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn     = 1'b0;
        pll_locked = 1'b0;
        ps_req     = 1'b0;
        ps_dir     = 1'b0;
        ps_count   = '0;
        test_reset();
        test_no_lock();
        test_lock_sequence();
        test_phase_inc();
        test_phase_dec();
        test_lock_loss();
        test_ps_timeout();
        test_unlock_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
